// File: rtl/if_id_skid_pkg.sv
// Shared IF/ID definitions for the Buceros RV32 core: bus widths,
// the reset PC and the NOP encoding that fills empty decode slots.
package if_id_skid_pkg;

  localparam int          INST_ADDR_BUS = 32;
  localparam int          INST_BUS      = 32;
  localparam logic [31:0] PC_RST_ADDR   = 32'h0000_0000;
  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST_DEF  = 32'h0000_0013;

endpackage

// File: rtl/if_id_skid_pipe_slot.sv
// One valid + payload register. Clear drops the valid bit but keeps
// the payload; a load with valid_d=0 also keeps the old payload, so
// the last PC stays visible while the slot is empty.
module if_id_skid_pipe_slot #(
  parameter int             W       = 64,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         load,
  input  logic         valid_d,
  input  logic [W-1:0] data_d,
  output logic         valid_q,
  output logic [W-1:0] data_q
);

  // Valid/payload register; clear wins over load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= RST_VAL;
    end else if (clear) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= valid_d;
      if (valid_d) begin
        data_q <= data_d;
      end
    end
  end

endmodule

// File: rtl/if_id_skid.sv
// IF/ID pipeline stage with optional one-entry skid buffer.
//
// Handshake: a beat moves on an interface in a cycle where valid and
// ready are both high at the rising edge. valid, once raised, is held
// with stable payload until taken (or the stage is flushed); ready may
// change freely. With SKID_EN=1, in_ready_o comes straight from a flop,
// so fetch sees no combinational path from decode's out_ready_i.
module if_id_skid
  import if_id_skid_pkg::*;
#(
  parameter int                ADDR_W   = INST_ADDR_BUS,
  parameter int                INST_W   = INST_BUS,
  parameter logic [ADDR_W-1:0] PC_RST   = PC_RST_ADDR[ADDR_W-1:0],
  parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEF[INST_W-1:0],
  parameter bit                SKID_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              hold_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [ADDR_W-1:0] in_pc_i,
  input  logic [INST_W-1:0] in_inst_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ADDR_W-1:0] out_pc_o,
  output logic [INST_W-1:0] out_inst_o
);

  localparam int PW = ADDR_W + INST_W;

  logic          accept;
  logic          drain;
  logic          out_load;
  logic          skid_valid;
  logic [PW-1:0] skid_q;
  logic [PW-1:0] in_data;
  logic [PW-1:0] out_d;
  logic          out_valid_d;
  logic [PW-1:0] out_q;

  assign in_data  = {in_pc_i, in_inst_i};
  assign accept   = in_valid_i & in_ready_o;
  // hold_i masks decode's ready so the output register freezes.
  assign drain    = out_valid_o & out_ready_i & ~hold_i;
  assign out_load = ~out_valid_o | drain;

  // Output slot source: the skid entry is older than any new input, so it goes first.
  always_comb begin
    out_d       = in_data;
    out_valid_d = accept;
    if (skid_valid) begin
      out_d       = skid_q;
      out_valid_d = 1'b1;
    end
  end

  if_id_skid_pipe_slot #(
    .W       (PW),
    .RST_VAL ({PC_RST, NOP_INST})
  ) u_out_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (flush_i),
    .load    (out_load),
    .valid_d (out_valid_d),
    .data_d  (out_d),
    .valid_q (out_valid_o),
    .data_q  (out_q)
  );

  generate
    if (SKID_EN) begin : g_skid
      logic skid_load;

      // Skid refills when its entry moves to the output, or captures a
      // beat that arrives while the output is stalled.
      assign skid_load  = (out_load & skid_valid) | (~out_load & accept);
      assign in_ready_o = ~skid_valid;

      if_id_skid_pipe_slot #(
        .W       (PW),
        .RST_VAL ('0)
      ) u_skid_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (flush_i),
        .load    (skid_load),
        .valid_d (accept),
        .data_d  (in_data),
        .valid_q (skid_valid),
        .data_q  (skid_q)
      );
    end else begin : g_no_skid
      assign skid_valid = 1'b0;
      assign skid_q     = '0;
      assign in_ready_o = out_load;
    end
  endgenerate

  // Empty slots always present a NOP so decode never sees stale encodings.
  assign out_pc_o   = out_q[PW-1:INST_W];
  assign out_inst_o = out_valid_o ? out_q[INST_W-1:0] : NOP_INST;

endmodule

// File: tb/tb_if_id_skid.sv
// Directed bench for if_id_skid: a skid instance (SKID_EN=1) and a
// plain register instance (SKID_EN=0) sharing clock and reset.
module tb_if_id_skid;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst_n;

  // SKID_EN=1 instance signals
  logic        flush, hold, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc, in_inst, out_pc, out_inst;

  // SKID_EN=0 instance signals
  logic        flush0, hold0, in_valid0, in_ready0, out_valid0, out_ready0;
  logic [31:0] in_pc0, in_inst0, out_pc0, out_inst0;

  int total;
  int bad;

  // Expected-value queue for in-order delivery checks
  logic [31:0] exp_q[$];

  if_id_skid #(.SKID_EN(1'b1)) dut (
    .clk (clk), .rst_n (rst_n), .flush_i (flush), .hold_i (hold),
    .in_valid_i (in_valid), .in_ready_o (in_ready),
    .in_pc_i (in_pc), .in_inst_i (in_inst),
    .out_valid_o (out_valid), .out_ready_i (out_ready),
    .out_pc_o (out_pc), .out_inst_o (out_inst)
  );

  if_id_skid #(.SKID_EN(1'b0)) dut0 (
    .clk (clk), .rst_n (rst_n), .flush_i (flush0), .hold_i (hold0),
    .in_valid_i (in_valid0), .in_ready_o (in_ready0),
    .in_pc_i (in_pc0), .in_inst_i (in_inst0),
    .out_valid_o (out_valid0), .out_ready_i (out_ready0),
    .out_pc_o (out_pc0), .out_inst_o (out_inst0)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [31:0] pc);
    in_valid = v;
    in_pc    = pc;
    in_inst  = inst_of(pc);
  endtask

  task automatic idle_all();
    flush = 0; hold = 0; in_valid = 0; in_pc = 0; in_inst = 0; out_ready = 0;
    flush0 = 0; hold0 = 0; in_valid0 = 0; in_pc0 = 0; in_inst0 = 0; out_ready0 = 0;
  endtask

  task automatic test_reset();
    idle_all();
    rst_n = 0;
    #12;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", out_valid); end
    total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", out_pc); end
    total++; if (out_inst !== NOP) begin bad++; $display("FAIL rst_inst got=%h exp=%h", out_inst, NOP); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", in_ready); end
    total++; if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1 || out_inst0 !== NOP) begin
      bad++; $display("FAIL rst_noskid got v=%b r=%b i=%h exp v=0 r=1 i=%h", out_valid0, in_ready0, out_inst0, NOP);
    end
    @(negedge clk);
    rst_n = 1;
    step();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL idle_after_rst got v=%b r=%b exp v=0 r=1", out_valid, in_ready);
    end
  endtask

  task automatic test_stream();
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      offer(1, 32'h100 + 32'(4 * i));
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_ready[%0d] got=%b exp=1", i, in_ready); end
      step();
      total++;
      if (out_valid !== 1'b1 || out_pc !== 32'h100 + 32'(4 * i) || out_inst !== inst_of(32'h100 + 32'(4 * i))) begin
        bad++;
        $display("FAIL stream_out[%0d] got v=%b pc=%h inst=%h exp v=1 pc=%h", i, out_valid, out_pc, out_inst,
                 32'h100 + 32'(4 * i));
      end
    end
    offer(0, 32'h0);
    step();
    total++; if (out_valid !== 1'b0 || out_inst !== NOP) begin
      bad++; $display("FAIL stream_end got v=%b inst=%h exp v=0 inst=%h", out_valid, out_inst, NOP);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] e;
    out_ready = 0;
    offer(1, 32'h200);
    step();
    offer(1, 32'h204);
    step();
    total++; if (out_pc !== 32'h200 || out_valid !== 1'b1) begin
      bad++; $display("FAIL bp_hold200 got v=%b pc=%h exp v=1 pc=200", out_valid, out_pc);
    end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_low got=%b exp=0", in_ready); end
    offer(1, 32'h208);
    step();
    total++; if (out_pc !== 32'h200 || in_ready !== 1'b0) begin
      bad++; $display("FAIL bp_stall got pc=%h r=%b exp pc=200 r=0", out_pc, in_ready);
    end
    // Release: expect 0x204 then 0x208, then empty.
    exp_q.push_back(32'h204);
    exp_q.push_back(32'h208);
    out_ready = 1;
    for (int c = 0; c < 4; c++) begin
      step();
      if (in_valid && in_pc == 32'h208 && out_valid && out_pc == 32'h208) offer(0, 32'h0);
      if (out_valid && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++; if (out_pc !== e) begin bad++; $display("FAIL bp_order got=%h exp=%h", out_pc, e); end
      end else if (out_valid) begin
        total++; bad++; $display("FAIL bp_extra got=%h exp=none", out_pc);
      end
    end
    total++; if (exp_q.size() != 0) begin
      bad++; $display("FAIL bp_lost got remaining=%0d exp=0", exp_q.size()); exp_q.delete();
    end
    offer(0, 32'h0);
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_hold();
    out_ready = 1;
    offer(1, 32'h300);
    step();
    offer(0, 32'h0);
    hold = 1;
    for (int c = 0; c < 3; c++) begin
      step();
      total++; if (out_valid !== 1'b1 || out_pc !== 32'h300 || out_inst !== inst_of(32'h300)) begin
        bad++; $display("FAIL hold_freeze[%0d] got v=%b pc=%h exp v=1 pc=300", c, out_valid, out_pc);
      end
    end
    hold = 0;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL hold_drain_once got v=%b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 0;
    offer(1, 32'h380);
    step();
    offer(1, 32'h384);
    step();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_fill got r=%b exp=0", in_ready); end
    offer(1, 32'h400);
    flush = 1;
    step();
    flush = 0;
    offer(0, 32'h0);
    total++; if (out_valid !== 1'b0 || out_inst !== NOP || in_ready !== 1'b1) begin
      bad++; $display("FAIL flush_full got v=%b i=%h r=%b exp v=0 i=%h r=1", out_valid, out_inst, in_ready, NOP);
    end
    total++; if (out_pc !== 32'h380) begin bad++; $display("FAIL flush_pc_keep got=%h exp=380", out_pc); end
    out_ready = 1;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_no_leak got v=%b pc=%h exp v=0", out_valid, out_pc); end
    // Flush while ready: offered beat is dropped anyway.
    offer(1, 32'h404);
    flush = 1;
    step();
    flush = 0;
    offer(0, 32'h0);
    total++; if (out_valid !== 1'b0 || out_pc !== 32'h380) begin
      bad++; $display("FAIL flush_drop got v=%b pc=%h exp v=0 pc=380", out_valid, out_pc);
    end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_drop_late got v=%b exp=0", out_valid); end
  endtask

  task automatic test_noskid();
    out_ready0 = 0;
    in_valid0 = 1; in_pc0 = 32'h500; in_inst0 = inst_of(32'h500);
    #1;
    total++; if (in_ready0 !== 1'b1) begin bad++; $display("FAIL ns_ready_empty got=%b exp=1", in_ready0); end
    step();
    in_valid0 = 0;
    #1;
    total++; if (out_valid0 !== 1'b1 || out_pc0 !== 32'h500 || in_ready0 !== 1'b0) begin
      bad++; $display("FAIL ns_stall got v=%b pc=%h r=%b exp v=1 pc=500 r=0", out_valid0, out_pc0, in_ready0);
    end
    out_ready0 = 1;
    #1;
    total++; if (in_ready0 !== 1'b1) begin bad++; $display("FAIL ns_ready_comb got=%b exp=1", in_ready0); end
    for (int i = 1; i < 3; i++) begin
      in_valid0 = 1; in_pc0 = 32'h500 + 32'(4 * i); in_inst0 = inst_of(in_pc0);
      step();
      total++; if (out_valid0 !== 1'b1 || out_pc0 !== 32'h500 + 32'(4 * i) || out_inst0 !== inst_of(32'h500 + 32'(4 * i))) begin
        bad++; $display("FAIL ns_b2b[%0d] got v=%b pc=%h exp v=1 pc=%h", i, out_valid0, out_pc0, 32'h500 + 32'(4 * i));
      end
    end
    in_valid0 = 0;
    step();
    total++; if (out_valid0 !== 1'b0 || out_inst0 !== NOP) begin
      bad++; $display("FAIL ns_end got v=%b i=%h exp v=0 i=%h", out_valid0, out_inst0, NOP);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 0;
    offer(1, 32'h600);
    step();
    offer(1, 32'h604);
    step();
    offer(0, 32'h0);
    #2;
    rst_n = 0;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_pc !== 32'h0 || out_inst !== NOP) begin
      bad++; $display("FAIL rst_mid got v=%b r=%b pc=%h i=%h exp v=0 r=1 pc=0 i=%h", out_valid, in_ready, out_pc, out_inst, NOP);
    end
    @(negedge clk);
    rst_n = 1;
    step();
  endtask

  // Test sequence and final report
  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_hold();
    test_flush();
    test_noskid();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
